// File: rtl/pe_feeder_if.sv
// Instruction, SRAM read and PE delivery bundle for pe_feeder.
// The slave modport is the feeder's view; master is its controller/SRAM/PE environment.
interface pe_feeder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 512
);
  logic              inst_valid;
  logic              inst_ready;
  logic [7:0]        inst_len;
  logic [ADDR_W-1:0] inst_nbase;
  logic [ADDR_W-1:0] inst_wbase;
  logic              flush;
  logic              nram_en;
  logic [ADDR_W-1:0] nram_addr;
  logic [DATA_W-1:0] nram_rdata;
  logic              wram_en;
  logic [ADDR_W-1:0] wram_addr;
  logic [DATA_W-1:0] wram_rdata;
  logic [DATA_W-1:0] pe_neuron;
  logic [DATA_W-1:0] pe_weight;
  logic [1:0]        pe_ctl;
  logic              pe_vld;
  logic              busy;
  logic [15:0]       done_cnt;

  modport slave (
    input  inst_valid, inst_len, inst_nbase, inst_wbase, flush, nram_rdata, wram_rdata,
    output inst_ready, nram_en, nram_addr, wram_en, wram_addr,
           pe_neuron, pe_weight, pe_ctl, pe_vld, busy, done_cnt
  );

  modport master (
    output inst_valid, inst_len, inst_nbase, inst_wbase, flush, nram_rdata, wram_rdata,
    input  inst_ready, nram_en, nram_addr, wram_en, wram_addr,
           pe_neuron, pe_weight, pe_ctl, pe_vld, busy, done_cnt
  );
endinterface

// File: rtl/pe_feeder.sv
// Issue stage for parallel_pe: walks neuron/weight SRAM addresses per instruction and
// aligns the 1-cycle read data with registered valid/ctl sideband, one beat per cycle.
module pe_feeder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 512
) (
  input  logic         clk,
  input  logic         rst_n,
  pe_feeder_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q;
  logic [7:0]        iter_q;
  logic [7:0]        len_q;
  logic [ADDR_W-1:0] nb_q;
  logic [ADDR_W-1:0] wb_q;
  logic              s1_vld_q;
  logic [1:0]        s1_ctl_q;
  logic [15:0]       done_cnt_q;

  logic       run;
  logic       last;
  logic       issue;
  logic [1:0] issue_ctl;
  logic       accept;
  logic       load;
  logic       pe_fire;

  assign run       = (state_q == RUN);
  assign last      = (iter_q == len_q - 8'd1);
  assign issue     = run && !bus.flush;
  assign issue_ctl = {last, iter_q == 8'd0};

  // A new instruction may only land on the final beat, which is what makes streams gapless.
  assign bus.inst_ready = !run || (last && !bus.flush);
  assign accept         = bus.inst_valid && bus.inst_ready;
  assign load           = accept && (bus.inst_len != 8'd0);

  assign bus.nram_en   = issue;
  assign bus.wram_en   = issue;
  assign bus.nram_addr = run ? nb_q + ADDR_W'(iter_q) : '0;
  assign bus.wram_addr = run ? wb_q + ADDR_W'(iter_q) : '0;

  // NOTE: flush gates the stage-1 beat combinationally so the beat already in flight
  // during the flush cycle never reaches the PE and never counts as a completion.
  assign pe_fire       = s1_vld_q && !bus.flush;
  assign bus.pe_vld    = pe_fire;
  assign bus.pe_ctl    = pe_fire ? s1_ctl_q : 2'b00;
  assign bus.pe_neuron = DATA_W'(bus.nram_rdata);
  assign bus.pe_weight = DATA_W'(bus.wram_rdata);
  assign bus.busy      = run || s1_vld_q;
  assign bus.done_cnt  = done_cnt_q;

  // NOTE: asynchronous active-low reset; every register, including the done counter,
  // returns to its idle value immediately, independent of the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      iter_q     <= 8'd0;
      len_q      <= 8'd0;
      nb_q       <= '0;
      wb_q       <= '0;
      s1_vld_q   <= 1'b0;
      s1_ctl_q   <= 2'b00;
      done_cnt_q <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every term above reads pre-edge state.
      if (load) begin
        state_q <= RUN;
        iter_q  <= 8'd0;
        len_q   <= bus.inst_len;
        nb_q    <= bus.inst_nbase;
        wb_q    <= bus.inst_wbase;
      end else if (run && (bus.flush || last)) begin
        state_q <= IDLE;
      end else if (run) begin
        iter_q <= iter_q + 8'd1;
      end

      s1_vld_q <= issue;
      s1_ctl_q <= issue ? issue_ctl : 2'b00;

      if (pe_fire && s1_ctl_q[1]) begin
        done_cnt_q <= done_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Scoreboard bench for pe_feeder: directed test-plan scenarios plus randomized instruction
// streams, expected beats derived from instruction fields and checked by a separate monitor.
module tb_pe_feeder;

  localparam int AW = 16;
  localparam int DW = 512;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pe_feeder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  pe_feeder #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [AW-1:0] na;
    logic [AW-1:0] wa;
    logic [1:0]    ctl;
  } beat_t;

  beat_t addr_q[$];
  beat_t pe_q[$];
  beat_t mb;
  int    pe_cycles[$];
  int    checks   = 0;
  int    passes   = 0;
  int    exp_done = 0;
  int    cyc      = 0;
  bit    mon_on   = 1'b0;

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a, input logic [15:0] salt);
    return {16{a, salt}};
  endfunction

  // Synchronous-read SRAM models: data appears the cycle after the enable.
  always @(posedge clk) begin
    if (bus.nram_en) bus.nram_rdata <= pattern(bus.nram_addr, 16'hA5A5);
    if (bus.wram_en) bus.wram_rdata <= pattern(bus.wram_addr, 16'h5A5A);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an SRAM read or a PE beat.
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.nram_en) begin
        if (addr_q.size() == 0) check("unexpected_en", bus.nram_en, 1'b0);
        else begin
          mb = addr_q.pop_front();
          check("nram_addr", bus.nram_addr, mb.na);
          check("wram_addr", bus.wram_addr, mb.wa);
          check("wram_en", bus.wram_en, 1'b1);
        end
      end
      if (bus.pe_vld) begin
        pe_cycles.push_back(cyc);
        if (pe_q.size() == 0) check("unexpected_pe_vld", bus.pe_vld, 1'b0);
        else begin
          mb = pe_q.pop_front();
          check("pe_ctl", bus.pe_ctl, mb.ctl);
          check("pe_neuron", bus.pe_neuron, pattern(mb.na, 16'hA5A5));
          check("pe_weight", bus.pe_weight, pattern(mb.wa, 16'h5A5A));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an instruction expands to len beats at consecutive (wrapping) addresses.
  task automatic push_inst(input int len, input logic [AW-1:0] nb, input logic [AW-1:0] wb);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.na  = nb + AW'(i);
      b.wa  = wb + AW'(i);
      b.ctl = {i == len - 1, i == 0};
      addr_q.push_back(b);
      pe_q.push_back(b);
    end
    if (len > 0) exp_done++;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int len, input logic [AW-1:0] nb, input logic [AW-1:0] wb,
                      input bit hold, input bit model);
    int n = 0;
    bus.inst_valid = 1'b1;
    bus.inst_len   = len[7:0];
    bus.inst_nbase = nb;
    bus.inst_wbase = wb;
    #1;
    while (!bus.inst_ready && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) check("ready_timeout", bus.inst_ready, 1'b1);
    if (model) push_inst(len, nb, wb);
    tick();
    if (!hold) bus.inst_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((addr_q.size() != 0 || pe_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    tick();
    tick();
    check({tag, "_addr_q_empty"}, addr_q.size(), 0);
    check({tag, "_pe_q_empty"}, pe_q.size(), 0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_ready"}, bus.inst_ready, 1'b1);
    check({tag, "_done_cnt"}, bus.done_cnt, exp_done);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_inst_ready"}, bus.inst_ready, 1'b1);
    check({tag, "_nram_en"}, bus.nram_en, 1'b0);
    check({tag, "_wram_en"}, bus.wram_en, 1'b0);
    check({tag, "_nram_addr"}, bus.nram_addr, 0);
    check({tag, "_wram_addr"}, bus.wram_addr, 0);
    check({tag, "_pe_vld"}, bus.pe_vld, 1'b0);
    check({tag, "_pe_ctl"}, bus.pe_ctl, 2'b00);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_done_cnt"}, bus.done_cnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    bus.inst_valid = 1'b0;
    bus.inst_len   = 8'd0;
    bus.inst_nbase = '0;
    bus.inst_wbase = '0;
    bus.flush      = 1'b0;

    #12;
    reset_checks("reset");
    rst_n  = 1'b1;
    mon_on = 1'b1;
    tick();

    // Single instruction with latency checks.
    send(4, 16'h0010, 16'h0020, 1'b0, 1'b1);
    check("t1_en_after_accept", bus.nram_en, 1'b1);
    check("t1_pe_vld_not_yet", bus.pe_vld, 1'b0);
    tick();
    check("t1_pe_vld_e2", bus.pe_vld, 1'b1);
    check("t1_first_ctl", bus.pe_ctl, 2'b01);
    drain("t1");

    // Single-beat instruction.
    send(1, 16'h0040, 16'h0041, 1'b0, 1'b1);
    check("t2_ready_high", bus.inst_ready, 1'b1);
    check("t2_en", bus.nram_en, 1'b1);
    tick();
    check("t2_pe_vld", bus.pe_vld, 1'b1);
    check("t2_ctl", bus.pe_ctl, 2'b11);
    drain("t2");

    // Back-to-back with valid held: no bubble.
    pe_cycles.delete();
    send(3, 16'h0100, 16'h0200, 1'b1, 1'b1);
    send(2, 16'h0300, 16'h0400, 1'b0, 1'b1);
    drain("t3");
    check("t3_beats", pe_cycles.size(), 5);
    check("t3_contiguous", pe_cycles.size() >= 5 ? pe_cycles[4] - pe_cycles[0] : -1, 4);

    // Zero-length instruction is consumed without issuing.
    pe_cycles.delete();
    send(0, 16'h0900, 16'h0A00, 1'b0, 1'b1);
    send(2, 16'h0B00, 16'h0C00, 1'b0, 1'b1);
    drain("t4");
    check("t4_beats", pe_cycles.size(), 2);

    // Address wrap.
    send(4, 16'hFFFE, 16'hFFFF, 1'b0, 1'b1);
    drain("t5");

    // Flush on the 3rd beat of a len-8 instruction: beats 1,2 read, only beat 1 delivered.
    pe_cycles.delete();
    begin
      beat_t b;
      for (int i = 0; i < 2; i++) begin
        b.na  = 16'h0500 + AW'(i);
        b.wa  = 16'h0600 + AW'(i);
        b.ctl = {1'b0, i == 0};
        addr_q.push_back(b);
        if (i == 0) pe_q.push_back(b);
      end
    end
    send(8, 16'h0500, 16'h0600, 1'b0, 1'b0);
    tick();
    tick();
    bus.flush = 1'b1;
    #1;
    check("t6_flush_ready", bus.inst_ready, 1'b0);
    check("t6_flush_en", bus.nram_en, 1'b0);
    check("t6_flush_pe_vld", bus.pe_vld, 1'b0);
    tick();
    bus.flush = 1'b0;
    #1;
    check("t6_after_en", bus.nram_en, 1'b0);
    check("t6_after_busy", bus.busy, 1'b0);
    check("t6_after_ready", bus.inst_ready, 1'b1);
    drain("t6");
    check("t6_beats", pe_cycles.size(), 1);

    // Randomized instruction stream.
    for (int k = 0; k < 40; k++) begin
      len = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 9));
      send(len, AW'($urandom), AW'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      if (!bus.inst_valid) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      end
    end
    bus.inst_valid = 1'b0;
    drain("rand");

    // Asynchronous reset mid-run.
    send(10, 16'h0700, 16'h0800, 1'b0, 1'b1);
    tick();
    tick();
    mon_on = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    addr_q.delete();
    pe_q.delete();
    exp_done = 0;
    tick();
    rst_n  = 1'b1;
    mon_on = 1'b1;
    send(2, 16'h0D00, 16'h0E00, 1'b0, 1'b1);
    drain("post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
